// File: rtl/tt_um_pipeline_cleaner_tx.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_pipeline_cleaner_tx
// Description : Tiny Tapeout tile that sends the byte on ui_in as one 8N1 UART
//               frame on uio[2]. A frame is started by a rising edge on
//               uio_in[0], which is synchronised to clk first. uio[1] shows
//               busy and uio[3] gives a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_pipeline_cleaner_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       C_UIO_OE   = 8'b0000_1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic             s1_q,      s1_d;
    logic             s2_q,      s2_d;
    logic             s3_q,      s3_d;
    logic [7:0]       shift_q,   shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [7:0]       data_q,    data_d;

    logic w_start_pulse;
    logic w_bit_end;

    // Unused inputs are gathered here so they are consumed explicitly.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:1]};

    // Two-flop synchroniser plus history flop; the pulse marks a fresh 0->1.
    always_comb begin
        s1_d = uio_in[0];
        s2_d = s1_q;
        s3_d = s2_q;
    end

    assign w_start_pulse = s2_q & ~s3_q;
    assign w_bit_end     = (cnt_q == C_CNT_LAST);

    // Frame sequencer: next state, baud counting, shifting and output levels.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        data_d    = data_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // Pulses seen in any other state are simply dropped.
                if (w_start_pulse) begin
                    state_d = ST_START;
                    shift_d = ui_in;
                    data_d  = ui_in;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d   = ST_DATA;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // tx takes the bit that becomes shift[0] after this shift.
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces an idle, quiet line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    assign uo_out  = data_q;
    assign uio_out = {4'b0000, done_q, tx_q, busy_q, 1'b0};
    assign uio_oe  = C_UIO_OE;

endmodule
`default_nettype wire
